// File: rtl/loop_kernel_engine.sv
// loop_kernel_engine: evaluates c[i] = (a[i] + K1*b[i]) * (a[i] + K2*b[i]) in two RAM passes.
// Optional macro LOOP_KERNEL_SAT_EN switches every add/multiply to saturating arithmetic.
`timescale 1ns/1ps
module loop_kernel_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 100,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned K1         = 2,
    parameter int unsigned K2         = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic                  i_wr_sel,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_sat_flag
);
    localparam int unsigned RAM_WORDS = 3 * DEPTH;
    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [RAM_AW-1:0]     B_BASE = RAM_AW'(DEPTH);
    localparam logic [RAM_AW-1:0]     C_BASE = RAM_AW'(2 * DEPTH);
    localparam logic [ADDR_WIDTH:0]   N_MAX  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] COEF1  = DATA_WIDTH'(K1);
    localparam logic [DATA_WIDTH-1:0] COEF2  = DATA_WIDTH'(K2);

    typedef enum logic [3:0] {
        StIdle, StP1Rb, StP1Ra, StP1Add, StP1Wr,
        StP2Rb, StP2Ra, StP2Rc, StP2Mul, StP2Wr, StFin
    } state_e;

    state_e                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_i;
    logic [ADDR_WIDTH:0]   r_n;
    logic [DATA_WIDTH-1:0] r_tmp;
    logic [DATA_WIDTH-1:0] r_acc;

    logic [DATA_WIDTH-1:0] r_mem [RAM_WORDS];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic                  r_host_rd_q;
    logic [DATA_WIDTH-1:0] r_rd_hold;

    logic                  w_start_acc;
    logic                  w_host_wr;
    logic                  w_host_rd;
    logic                  w_last;
    logic [RAM_AW-1:0]     w_idx;
    logic                  w_ram_we;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_wdata;
    logic [DATA_WIDTH-1:0] w_mul_b;
    logic [DATA_WIDTH-1:0] w_mul_res;
    logic [DATA_WIDTH-1:0] w_add_res;

    assign w_start_acc = i_start && (r_state == StIdle);
    assign w_host_wr   = i_wr_en && !r_busy && ({1'b0, i_wr_addr} < N_MAX);
    assign w_host_rd   = i_rd_en && !r_busy && !w_host_wr && ({1'b0, i_rd_addr} < N_MAX);
    assign w_last      = ({1'b0, r_i} + (ADDR_WIDTH + 1)'(1)) >= r_n;
    assign w_idx       = RAM_AW'(r_i);

    // Single RAM port: host traffic only happens while idle, so it never collides with the FSM.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = r_acc;
        if (w_host_wr) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = (i_wr_sel ? B_BASE : '0) + RAM_AW'(i_wr_addr);
            w_ram_wdata = i_wr_data;
        end else if (w_host_rd) begin
            w_ram_addr = C_BASE + RAM_AW'(i_rd_addr);
        end else begin
            case (r_state)
                StP1Rb, StP2Rb: w_ram_addr = B_BASE + w_idx;
                StP1Ra, StP2Ra: w_ram_addr = w_idx;
                StP2Rc:         w_ram_addr = C_BASE + w_idx;
                StP1Wr, StP2Wr: begin
                    w_ram_we   = 1'b1;
                    w_ram_addr = C_BASE + w_idx;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wdata;
        end else begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    // Host read data comes straight from the RAM output for one cycle, then is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_host_rd_q <= 1'b0;
            r_rd_hold   <= '0;
        end else begin
            r_host_rd_q <= w_host_rd;
            if (r_host_rd_q) r_rd_hold <= r_ram_q;
        end
    end

    assign o_rd_data = r_host_rd_q ? r_ram_q : r_rd_hold;

    always_comb begin
        w_mul_b = r_acc;
        if (r_state == StP1Ra) begin
            w_mul_b = COEF1;
        end else if (r_state == StP2Ra) begin
            w_mul_b = COEF2;
        end
    end

`ifdef LOOP_KERNEL_SAT_EN
    logic [2*DATA_WIDTH-1:0] w_mul_full;
    logic [DATA_WIDTH:0]     w_add_full;
    logic                    w_mul_ovf;
    logic                    w_add_ovf;
    logic                    w_sat_set;
    logic                    r_sat;

    assign w_mul_full = {{DATA_WIDTH{1'b0}}, r_ram_q} * {{DATA_WIDTH{1'b0}}, w_mul_b};
    assign w_add_full = {1'b0, r_ram_q} + {1'b0, r_tmp};
    assign w_mul_ovf  = |w_mul_full[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_add_ovf  = w_add_full[DATA_WIDTH];
    assign w_mul_res  = w_mul_ovf ? '1 : w_mul_full[DATA_WIDTH-1:0];
    assign w_add_res  = w_add_ovf ? '1 : w_add_full[DATA_WIDTH-1:0];
    assign w_sat_set  = ((r_state == StP1Ra || r_state == StP2Ra || r_state == StP2Mul) && w_mul_ovf)
                     || ((r_state == StP1Add || r_state == StP2Rc) && w_add_ovf);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat <= 1'b0;
        end else if (w_start_acc) begin
            r_sat <= 1'b0;
        end else if (w_sat_set) begin
            r_sat <= 1'b1;
        end
    end

    assign o_sat_flag = r_sat;
`else
    assign w_mul_res  = r_ram_q * w_mul_b;
    assign w_add_res  = r_ram_q + r_tmp;
    assign o_sat_flag = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_i     <= '0;
            r_n     <= '0;
            r_tmp   <= '0;
            r_acc   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start_acc) begin
                        r_n <= (i_len > N_MAX) ? N_MAX : i_len;
                        r_i <= '0;
                        // Empty run skips straight to the done pulse without raising busy.
                        if (i_len == '0) begin
                            r_state <= StFin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StP1Rb;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                StP1Rb:  r_state <= StP1Ra;
                StP1Ra: begin
                    r_tmp   <= w_mul_res;
                    r_state <= StP1Add;
                end
                StP1Add: begin
                    r_acc   <= w_add_res;
                    r_state <= StP1Wr;
                end
                StP1Wr: begin
                    if (w_last) begin
                        r_i     <= '0;
                        r_state <= StP2Rb;
                    end else begin
                        r_i     <= r_i + ADDR_WIDTH'(1);
                        r_state <= StP1Rb;
                    end
                end
                StP2Rb:  r_state <= StP2Ra;
                StP2Ra: begin
                    r_tmp   <= w_mul_res;
                    r_state <= StP2Rc;
                end
                StP2Rc: begin
                    r_acc   <= w_add_res;
                    r_state <= StP2Mul;
                end
                StP2Mul: begin
                    r_acc   <= w_mul_res;
                    r_state <= StP2Wr;
                end
                StP2Wr: begin
                    if (w_last) begin
                        r_i     <= '0;
                        r_state <= StFin;
                        r_done  <= 1'b1;
                    end else begin
                        r_i     <= r_i + ADDR_WIDTH'(1);
                        r_state <= StP2Rb;
                    end
                end
                StFin: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
